// File: rtl/transmit_shifter.sv
// transmit_shifter
//   Serialises one latched payload word onto TX as a frame:
//   start bit (0), DATA_WIDTH data bits LSB first, optional parity bit,
//   STOP_BITS stop bits (1). BREAK tells the transmit controller that the
//   frame is finished.
//
// Ports
//   CLK    in   1           system clock, rising edge
//   RESET  in   1           asynchronous active-low reset
//   STATE  in   1           controller mode: 0 idle, 1 busy (request/hold)
//   BCLK   in   1           baud tick, one CLK wide per bit period
//   DATA   in   DATA_WIDTH  payload, sampled only in the latch cycle
//   TX     out  1           serial line, idle high, registered
//   BREAK  out  1           one-CLK end-of-frame pulse, registered
//
// phase      | meaning
// -----------+-------------------------------------------------------------
// PH_IDLE    | line idle, waiting for STATE=1 to latch DATA
// PH_WAIT    | payload latched, line still high until the first BCLK
// PH_START   | start bit (0) on the line
// PH_DATA    | data bit cnt_q on the line
// PH_PARITY  | parity bit on the line
// PH_STOP    | stop bit cnt_q on the line (only reached when STOP_BITS > 1)
// PH_DONE    | frame finished, line high, waiting for STATE=0

module transmit_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  STATE,
  input  logic                  BCLK,
  input  logic [DATA_WIDTH-1:0] DATA,
  output logic                  TX,
  output logic                  BREAK
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_WAIT,
    PH_START,
    PH_DATA,
    PH_PARITY,
    PH_STOP,
    PH_DONE
  } phase_t;

  phase_t                phase_q, phase_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  par_q,   par_d;
  logic                  tx_q,    tx_d;
  logic                  brk_q,   brk_d;
  logic                  go_stop;

  always_comb begin
    phase_d = phase_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    tx_d    = tx_q;
    brk_d   = 1'b0;
    go_stop = 1'b0;

    case (phase_q)
      PH_IDLE: begin
        tx_d = 1'b1;
        if (STATE) begin
          shreg_d = DATA;
          cnt_d   = '0;
          // Parity is taken from the word being latched here, so later
          // changes on DATA cannot reach the parity bit.
          par_d   = (^DATA) ^ (PARITY_ODD != 0);
          phase_d = PH_WAIT;
        end
      end

      PH_DONE: begin
        if (!STATE) begin
          phase_d = PH_IDLE;
        end
      end

      default: begin
        if (!STATE) begin
          // Abort: line back to idle at once, no end-of-frame pulse.
          phase_d = PH_IDLE;
          tx_d    = 1'b1;
        end else if (BCLK) begin
          case (phase_q)
            PH_WAIT: begin
              phase_d = PH_START;
              tx_d    = 1'b0;
            end

            PH_START: begin
              phase_d = PH_DATA;
              tx_d    = shreg_q[0];
            end

            PH_DATA: begin
              if (cnt_q == LAST_BIT) begin
                if (PARITY_EN != 0) begin
                  phase_d = PH_PARITY;
                  tx_d    = par_q;
                end else begin
                  go_stop = 1'b1;
                end
              end else begin
                shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
                tx_d    = shreg_q[1];
                cnt_d   = cnt_q + CNT_ONE;
              end
            end

            PH_PARITY: begin
              go_stop = 1'b1;
            end

            PH_STOP: begin
              cnt_d = cnt_q + CNT_ONE;
              if (cnt_q + CNT_ONE == STOP_LAST) begin
                phase_d = PH_DONE;
                brk_d   = 1'b1;
              end
            end

            default: begin
              phase_d = PH_IDLE;
              tx_d    = 1'b1;
            end
          endcase
        end
      end
    endcase

    // BREAK fires on the tick that puts the last stop bit on the line.
    // That bit still gets a full period: any new frame must latch and then
    // wait for a fresh BCLK before its start bit can pull the line low.
    if (go_stop) begin
      tx_d = 1'b1;
      if (STOP_BITS == 1) begin
        phase_d = PH_DONE;
        brk_d   = 1'b1;
      end else begin
        phase_d = PH_STOP;
        cnt_d   = CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      phase_q <= PH_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      brk_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      brk_q   <= brk_d;
    end
  end

  assign TX    = tx_q;
  assign BREAK = brk_q;

endmodule

// File: tb/tb_transmit_shifter.sv
module tb_transmit_shifter;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b0;
  logic       STATE = 1'b0;
  logic       BCLK  = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic [7:0] data2 = 8'h00;
  logic [7:0] data3 = 8'h00;
  logic [3:0] tx_w;
  logic [3:0] brk_w;

  int total = 0;
  int bad   = 0;
  int brk_seen0 = 0;

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (brk_w[0] === 1'b1) brk_seen0 <= brk_seen0 + 1;
  end

  // 0: defaults, 1: even parity, 2: odd parity, 3: two stop bits
  transmit_shifter u_def (
    .CLK(CLK), .RESET(RESET), .STATE(STATE), .BCLK(BCLK),
    .DATA(data0), .TX(tx_w[0]), .BREAK(brk_w[0])
  );
  transmit_shifter #(.PARITY_EN(1), .PARITY_ODD(0)) u_pev (
    .CLK(CLK), .RESET(RESET), .STATE(STATE), .BCLK(BCLK),
    .DATA(data1), .TX(tx_w[1]), .BREAK(brk_w[1])
  );
  transmit_shifter #(.PARITY_EN(1), .PARITY_ODD(1)) u_pod (
    .CLK(CLK), .RESET(RESET), .STATE(STATE), .BCLK(BCLK),
    .DATA(data2), .TX(tx_w[2]), .BREAK(brk_w[2])
  );
  transmit_shifter #(.STOP_BITS(2)) u_stp (
    .CLK(CLK), .RESET(RESET), .STATE(STATE), .BCLK(BCLK),
    .DATA(data3), .TX(tx_w[3]), .BREAK(brk_w[3])
  );

  task automatic set_data(input int sel, input logic [7:0] v);
    case (sel)
      0: data0 = v;
      1: data1 = v;
      2: data2 = v;
      default: data3 = v;
    endcase
  endtask

  task automatic end_frame();
    STATE = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic pulse_bclk(input int gap);
    repeat (gap) @(negedge CLK);
    BCLK = 1'b1;
    @(negedge CLK);
    BCLK = 1'b0;
  endtask

  // Latch dv into DUT sel, send n BCLKs 16 CLK apart, sample TX after each.
  // DATA is inverted right after latch; it must not reach the line.
  task automatic run_frame(input int sel, input logic [7:0] dv, input int n,
                           input bit bclk_at_latch,
                           output logic [15:0] bits, output int brk_at,
                           output int brk_cnt, output bit stable_ok);
    logic prev;
    bits = '0; brk_at = 0; brk_cnt = 0; stable_ok = 1'b1;
    set_data(sel, dv);
    STATE = 1'b1;
    BCLK  = bclk_at_latch;
    @(negedge CLK);
    BCLK = 1'b0;
    set_data(sel, ~dv);
    prev = 1'b1;
    for (int k = 1; k <= n; k++) begin
      repeat (15) begin
        @(negedge CLK);
        if (tx_w[sel] !== prev) stable_ok = 1'b0;
        if (brk_w[sel] === 1'b1) brk_cnt++;
      end
      BCLK = 1'b1;
      @(negedge CLK);
      BCLK = 1'b0;
      bits[k-1] = tx_w[sel];
      prev = tx_w[sel];
      if (brk_w[sel] === 1'b1) begin
        brk_cnt++;
        if (brk_at == 0) brk_at = k;
      end
    end
    repeat (5) begin
      @(negedge CLK);
      if (tx_w[sel] !== 1'b1) stable_ok = 1'b0;
      if (brk_w[sel] === 1'b1) brk_cnt++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    total++;
    if (tx_w !== 4'hF) begin
      bad++; $display("FAIL reset_tx: got %b want 1111", tx_w);
    end
    total++;
    if (brk_w !== 4'h0) begin
      bad++; $display("FAIL reset_break: got %b want 0000", brk_w);
    end
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    total++;
    if (tx_w !== 4'hF) begin
      bad++; $display("FAIL post_reset_tx: got %b want 1111", tx_w);
    end
    total++;
    if (brk_w !== 4'h0) begin
      bad++; $display("FAIL post_reset_break: got %b want 0000", brk_w);
    end
  endtask

  task automatic check_frame(input string name, input int sel, input logic [7:0] dv,
                             input int n, input bit bl, input logic [15:0] exp_bits,
                             input int exp_brk);
    logic [15:0] bits;
    int brk_at, brk_cnt;
    bit stable_ok;
    run_frame(sel, dv, n, bl, bits, brk_at, brk_cnt, stable_ok);
    total++;
    if (bits !== exp_bits) begin
      bad++; $display("FAIL %s_bits: got %b want %b", name, bits, exp_bits);
    end
    total++;
    if (brk_at !== exp_brk) begin
      bad++; $display("FAIL %s_break_pos: got %0d want %0d", name, brk_at, exp_brk);
    end
    total++;
    if (brk_cnt !== 1) begin
      bad++; $display("FAIL %s_break_width: got %0d want 1", name, brk_cnt);
    end
    total++;
    if (stable_ok !== 1'b1) begin
      bad++; $display("FAIL %s_tx_between_ticks: got %0d want 1", name, stable_ok);
    end
  endtask

  task automatic test_default();
    // 0,1,0,1,0,0,1,0,1,1 (index 0 first)
    check_frame("dflt_a5", 0, 8'hA5, 10, 1'b0, 16'b0000001101001010, 10);
    end_frame();
  endtask

  task automatic test_parity();
    // 0,1,1,1,0,0,0,0,0,P,1
    check_frame("par_even", 1, 8'h07, 11, 1'b0, 16'b0000011000001110, 11);
    end_frame();
    check_frame("par_odd", 2, 8'h07, 11, 1'b0, 16'b0000010000001110, 11);
    end_frame();
  endtask

  task automatic test_stop2();
    check_frame("stop2", 3, 8'h00, 11, 1'b0, 16'b0000011000000000, 11);
    end_frame();
  endtask

  task automatic test_back_to_back();
    int b0;
    bit ok;
    check_frame("b2b_first", 0, 8'hA5, 10, 1'b0, 16'b0000001101001010, 10);
    // STATE still high in DONE: further ticks must not start a new frame
    b0 = brk_seen0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat (15) begin
        @(negedge CLK);
        if (tx_w[0] !== 1'b1) ok = 1'b0;
      end
      BCLK = 1'b1; @(negedge CLK); BCLK = 1'b0;
      if (tx_w[0] !== 1'b1) ok = 1'b0;
    end
    total++;
    if (ok !== 1'b1) begin
      bad++; $display("FAIL b2b_no_relatch_tx: got %0d want 1", ok);
    end
    total++;
    if (brk_seen0 - b0 !== 0) begin
      bad++; $display("FAIL b2b_no_relatch_break: got %0d want 0", brk_seen0 - b0);
    end
    end_frame();
    // second rise, with a BCLK in the latch cycle that must be ignored
    check_frame("b2b_second", 0, 8'h3C, 10, 1'b1, 16'b0000001001111000, 10);
    end_frame();
  endtask

  task automatic test_abort();
    int b0;
    bit ok;
    set_data(0, 8'hA5);
    STATE = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 5; i++) pulse_bclk(15);
    total++;
    if (tx_w[0] !== 1'b0) begin
      bad++; $display("FAIL abort_bit3: got %b want 0", tx_w[0]);
    end
    b0 = brk_seen0;
    repeat (3) @(negedge CLK);
    STATE = 1'b0;
    @(negedge CLK);
    total++;
    if (tx_w[0] !== 1'b1) begin
      bad++; $display("FAIL abort_tx_next_edge: got %b want 1", tx_w[0]);
    end
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat (15) begin
        @(negedge CLK);
        if (tx_w[0] !== 1'b1) ok = 1'b0;
      end
      BCLK = 1'b1; @(negedge CLK); BCLK = 1'b0;
      if (tx_w[0] !== 1'b1) ok = 1'b0;
    end
    total++;
    if (ok !== 1'b1) begin
      bad++; $display("FAIL abort_tx_stays_high: got %0d want 1", ok);
    end
    total++;
    if (brk_seen0 - b0 !== 0) begin
      bad++; $display("FAIL abort_no_break: got %0d want 0", brk_seen0 - b0);
    end
    check_frame("abort_fresh", 0, 8'h5A, 10, 1'b0, 16'b0000001010110100, 10);
    end_frame();
  endtask

  task automatic test_reset_midframe();
    int b0;
    bit ok;
    set_data(0, 8'h1F);
    STATE = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 7; i++) pulse_bclk(15);
    total++;
    if (tx_w[0] !== 1'b0) begin
      bad++; $display("FAIL rst_bit5_before: got %b want 0", tx_w[0]);
    end
    b0 = brk_seen0;
    #2;
    RESET = 1'b0;
    STATE = 1'b0;
    #1;
    total++;
    if (tx_w[0] !== 1'b1) begin
      bad++; $display("FAIL rst_async_tx: got %b want 1", tx_w[0]);
    end
    total++;
    if (brk_w !== 4'h0) begin
      bad++; $display("FAIL rst_async_break: got %b want 0000", brk_w);
    end
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat (15) begin
        @(negedge CLK);
        if (tx_w[0] !== 1'b1) ok = 1'b0;
      end
      BCLK = 1'b1; @(negedge CLK); BCLK = 1'b0;
      if (tx_w[0] !== 1'b1) ok = 1'b0;
    end
    total++;
    if (ok !== 1'b1) begin
      bad++; $display("FAIL rst_no_resume_tx: got %0d want 1", ok);
    end
    total++;
    if (brk_seen0 - b0 !== 0) begin
      bad++; $display("FAIL rst_no_resume_break: got %0d want 0", brk_seen0 - b0);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
